// File: rtl/logic_capture_pkg.sv
// rtl/logic_capture_pkg.sv - shared state and trigger-mode encodings for the logic capture block
package logic_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRE       = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POST      = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  localparam logic [1:0] TRIG_IMM  = 2'd0;
  localparam logic [1:0] TRIG_ANY  = 2'd1;
  localparam logic [1:0] TRIG_RISE = 2'd2;
  localparam logic [1:0] TRIG_PAT  = 2'd3;

endpackage

// File: rtl/capture_sync.sv
// rtl/capture_sync.sv - synchronises the external sample clock and data, emits a strobe per rising edge
module capture_sync #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             async_clk,
  input  logic [WIDTH-1:0] async_data,
  output logic [WIDTH-1:0] sync_data,
  output logic             strobe
);

  // clock and data share one chain so they see identical latency
  logic [WIDTH:0] stage_q [STAGES];
  logic [WIDTH:0] stage_d [STAGES];
  logic           clk_prev_q;
  logic           clk_prev_d;

  always_comb begin
    stage_d[0] = {async_clk, async_data};
    for (int i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
    clk_prev_d = stage_q[STAGES-1][WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q    <= '{default: '0};
      clk_prev_q <= 1'b0;
    end else begin
      stage_q    <= stage_d;
      clk_prev_q <= clk_prev_d;
    end
  end

  assign sync_data = stage_q[STAGES-1][WIDTH-1:0];
  assign strobe    = stage_q[STAGES-1][WIDTH] & ~clk_prev_q;

endmodule

// File: rtl/logic_capture.sv
// rtl/logic_capture.sv - triggered logic-analyser capture into a DEPTH-deep ring with pre-trigger history
module logic_capture
  import logic_capture_pkg::*;
#(
  parameter int CHANNELS    = 5,
  parameter int DEPTH       = 15,
  parameter int PRETRIG     = 3,
  parameter int SYNC_STAGES = 2,
  localparam int TW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                smp_clk,
  input  logic [CHANNELS-1:0] smp_data,
  input  logic                arm,
  input  logic [1:0]          trig_mode,
  input  logic [TW-1:0]       trig_ch,
  input  logic [CHANNELS-1:0] trig_pat,
  input  logic [CHANNELS-1:0] trig_mask,
  input  logic [PW-1:0]       rd_idx,
  output logic [CHANNELS-1:0] rd_data,
  output logic                busy,
  output logic                done
);

  localparam int CW     = $clog2(DEPTH + 1);
  localparam int POST_N = DEPTH - PRETRIG - 1;
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
  localparam logic [PW:0]   DEPTH_W   = (PW + 1)'(DEPTH);
  localparam logic [CW-1:0] PRE_LAST  = CW'((PRETRIG > 0) ? PRETRIG - 1 : 0);
  localparam logic [CW-1:0] POST_LAST = CW'((POST_N > 0) ? POST_N - 1 : 0);

  logic [CHANNELS-1:0] sample;
  logic                strobe;

  capture_sync #(.WIDTH(CHANNELS), .STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .async_clk  (smp_clk),
    .async_data (smp_data),
    .sync_data  (sample),
    .strobe     (strobe)
  );

  state_t              state_q, state_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, start_ptr_q, start_ptr_d, ptr_next, rd_addr;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CHANNELS-1:0] prev_sample_q, prev_sample_d, rd_data_q, rd_data_d;
  logic [CHANNELS-1:0] sh_new, sh_old;
  logic                prev_valid_q, prev_valid_d, trig_hit, we;
  logic [PW:0]         rd_sum, rd_wrap;
  logic [CHANNELS-1:0] mem [DEPTH];

  always_comb begin
    sh_new = sample >> trig_ch;
    sh_old = prev_sample_q >> trig_ch;
    unique case (trig_mode)
      TRIG_IMM:  trig_hit = 1'b1;
      TRIG_ANY:  trig_hit = prev_valid_q & (sh_new[0] ^ sh_old[0]);
      TRIG_RISE: trig_hit = prev_valid_q & sh_new[0] & ~sh_old[0];
      default:   trig_hit = ((sample ^ trig_pat) & trig_mask) == '0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    start_ptr_d   = start_ptr_q;
    cnt_d         = cnt_q;
    prev_valid_d  = prev_valid_q;
    prev_sample_d = strobe ? sample : prev_sample_q;
    we            = 1'b0;
    ptr_next      = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    if (arm) begin
      state_d      = ST_PRE;
      wr_ptr_d     = '0;
      cnt_d        = '0;
      prev_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_PRE: begin
          if (PRETRIG == 0) begin
            state_d = ST_WAIT_TRIG;
          end else if (strobe) begin
            we       = 1'b1;
            wr_ptr_d = ptr_next;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == PRE_LAST) begin
              state_d = ST_WAIT_TRIG;
              cnt_d   = '0;
            end
          end
        end
        ST_WAIT_TRIG: begin
          if (strobe) begin
            we           = 1'b1;
            wr_ptr_d     = ptr_next;
            prev_valid_d = 1'b1;
            if (trig_hit) begin
              cnt_d = '0;
              if (POST_N == 0) begin
                state_d     = ST_DONE;
                start_ptr_d = ptr_next;
              end else begin
                state_d = ST_POST;
              end
            end
          end
        end
        ST_POST: begin
          if (strobe) begin
            we       = 1'b1;
            wr_ptr_d = ptr_next;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == POST_LAST) begin
              state_d     = ST_DONE;
              start_ptr_d = ptr_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // logical-to-physical address by a single conditional subtract; rd_data only refreshes in DONE
  always_comb begin
    rd_sum    = {1'b0, start_ptr_q} + {1'b0, rd_idx};
    rd_wrap   = (rd_sum >= DEPTH_W) ? rd_sum - DEPTH_W : rd_sum;
    rd_addr   = rd_wrap[PW-1:0];
    rd_data_d = rd_data_q;
    if (state_q == ST_DONE) begin
      rd_data_d = ({1'b0, rd_idx} >= DEPTH_W) ? '0 : mem[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      start_ptr_q   <= '0;
      cnt_q         <= '0;
      prev_sample_q <= '0;
      prev_valid_q  <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      start_ptr_q   <= start_ptr_d;
      cnt_q         <= cnt_d;
      prev_sample_q <= prev_sample_d;
      prev_valid_q  <= prev_valid_d;
      rd_data_q     <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_ptr_q] <= sample;
    end
  end

  assign rd_data = rd_data_q;
  assign busy    = (state_q == ST_PRE) || (state_q == ST_WAIT_TRIG) || (state_q == ST_POST);
  assign done    = (state_q == ST_DONE);

endmodule
